// File: rtl/nibble_mult_sequencer.sv
// WIDTH x WIDTH unsigned multiplier that time-shares one external 4x4 array multiplier,
// issuing one nibble pair per clock (row-major) and shift-accumulating the partial products.
module nibble_mult_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic [3:0]           mul_a,
   output logic [3:0]           mul_b,
   input  logic [7:0]           mul_p
);
   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [IW-1:0]        i_q, j_q, i_d, j_d;
   logic                 last_pair;
   logic [2*WIDTH-1:0]   pp_shifted;
   logic                 in_ready_q, out_valid_q, busy_q;
   logic [3:0]           mul_a_q, mul_b_q;

   function automatic logic [3:0] nib(input logic [WIDTH-1:0] v, input logic [IW-1:0] k);
      return 4'(v >> (4 * k));
   endfunction

   always_comb begin
      last_pair  = (i_q == IW'(NIB - 1)) && (j_q == IW'(NIB - 1));
      pp_shifted = (2*WIDTH)'(mul_p) << (4 * (32'(i_q) + 32'(j_q)));
      i_d        = i_q;
      j_d        = j_q + 1'b1;
      if (j_q == IW'(NIB - 1)) begin
         j_d = '0;
         i_d = i_q + 1'b1;
      end
   end

   // mul_a/mul_b are registered, so each CALC edge preloads the nibbles of the pair
   // that the following edge will accumulate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  state_q    <= CALC;
                  a_q        <= op_a;
                  b_q        <= op_b;
                  acc_q      <= '0;
                  i_q        <= '0;
                  j_q        <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  mul_a_q    <= op_a[3:0];
                  mul_b_q    <= op_b[3:0];
               end
            end
            CALC: begin
               acc_q <= acc_q + pp_shifted;
               if (last_pair) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  i_q         <= '0;
                  j_q         <= '0;
                  mul_a_q     <= '0;
                  mul_b_q     <= '0;
               end else begin
                  i_q     <= i_d;
                  j_q     <= j_d;
                  mul_a_q <= nib(a_q, i_d);
                  mul_b_q <= nib(b_q, j_d);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = acc_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_nibble_mult_sequencer.sv
// Bench for nibble_mult_sequencer: WIDTH 8 directed vectors, WIDTH 16 and 4 random traffic,
// each instance checked every cycle against a transaction-level timing/arithmetic model.
module tb_nibble_mult_sequencer;
   logic        clk;
   logic        rst_n;
   int unsigned checks   = 0;
   int unsigned passes   = 0;
   int unsigned finished = 0;
   bit          start_rnd = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int unsigned WG  = (g == 0) ? 8 : ((g == 1) ? 16 : 4);
      localparam int unsigned NIB = WG / 4;
      localparam int unsigned N   = NIB * NIB;

      logic              iv, ir, ov, ordy, bsy;
      logic [WG-1:0]     a, b;
      logic [2*WG-1:0]   p;
      logic [3:0]        ma, mb;
      logic [7:0]        mp;

      assign mp = ma * mb;

      nibble_mult_sequencer #(.WIDTH(WG)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv),
         .in_ready  (ir),
         .op_a      (a),
         .op_b      (b),
         .out_valid (ov),
         .out_ready (ordy),
         .product   (p),
         .busy      (bsy),
         .mul_a     (ma),
         .mul_b     (mb),
         .mul_p     (mp)
      );

      // Model: a transaction is pending from acceptance until its output handshake;
      // its result is presented once N cycles have elapsed since acceptance.
      bit            pend;
      int unsigned   cnt;
      logic [WG-1:0] ea, eb;

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pend <= 1'b0;
            cnt  <= 0;
         end else if (pend) begin
            if (cnt >= N) begin
               if (ordy) pend <= 1'b0;
            end else cnt <= cnt + 1;
         end else if (iv) begin
            pend <= 1'b1;
            cnt  <= 0;
            ea   <= a;
            eb   <= b;
         end
      end

      always @(negedge clk) begin
         logic [3:0]      ema, emb;
         logic [2*WG-1:0] ep;
         ema = '0;
         emb = '0;
         if (pend && cnt < N) begin
            ema = 4'(ea >> (4 * (cnt / NIB)));
            emb = 4'(eb >> (4 * (cnt % NIB)));
         end
         ep = (2*WG)'(ea) * (2*WG)'(eb);
         chk($sformatf("w%0d_in_ready", WG), 32'(ir), 32'(!pend));
         chk($sformatf("w%0d_out_valid", WG), 32'(ov), 32'(pend && cnt >= N));
         chk($sformatf("w%0d_busy", WG), 32'(bsy), 32'(pend));
         chk($sformatf("w%0d_mul_ab", WG), {24'd0, ma, mb}, {24'd0, ema, emb});
         if (pend && cnt >= N) chk($sformatf("w%0d_product", WG), 32'(p), 32'(ep));
         if (!rst_n) chk($sformatf("w%0d_product_rst", WG), 32'(p), 32'd0);
      end

      if (g == 0) begin : g_dir
         task automatic rst_vals(input string nm);
            chk({nm, "_in_ready"}, 32'(ir), 32'd1);
            chk({nm, "_out_valid"}, 32'(ov), 32'd0);
            chk({nm, "_busy"}, 32'(bsy), 32'd0);
            chk({nm, "_product"}, 32'(p), 32'd0);
            chk({nm, "_mul"}, {24'd0, ma, mb}, 32'd0);
         endtask

         // Called just after a rising edge with the DUT idle and out_ready high.
         task automatic xact(input logic [7:0] ta, input logic [7:0] tb_v,
                             input logic [15:0] ep, input logic [31:0] pairs);
            chk("x_in_ready_idle", 32'(ir), 32'd1);
            iv = 1'b1;
            a  = ta;
            b  = tb_v;
            @(posedge clk);
            #1 iv = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("x_pair", {24'd0, ma, mb}, {24'd0, pairs[31-8*k -: 8]});
               chk("x_no_valid_yet", 32'(ov), 32'd0);
            end
            @(negedge clk);
            chk("x_out_valid", 32'(ov), 32'd1);
            chk("x_product", 32'(p), 32'(ep));
            chk("x_in_ready_done", 32'(ir), 32'd0);
            @(posedge clk);
            #1;
         endtask

         initial begin
            rst_n = 1'b0;
            iv    = 1'b0;
            a     = '0;
            b     = '0;
            ordy  = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst_vals("reset");
            @(negedge clk) rst_n = 1'b1;
            @(posedge clk);
            #1;

            xact(8'hFF, 8'hFF, 16'hFE01, 32'hFF_FF_FF_FF);
            xact(8'h3C, 8'hA5, 16'h26AC, 32'hC5_CA_35_3A);
            xact(8'h00, 8'hB7, 16'h0000, 32'h07_0B_07_0B);
            xact(8'h01, 8'hB7, 16'h00B7, 32'h17_1B_07_0B);

            // Sink stalls while a new operand pair is already offered.
            ordy = 1'b0;
            iv   = 1'b1;
            a    = 8'h5A;
            b    = 8'h0C;
            @(posedge clk);
            #1 a = 8'h77;
            b = 8'h99;
            repeat (4) @(posedge clk);
            repeat (10) begin
               @(negedge clk);
               chk("stall_out_valid", 32'(ov), 32'd1);
               chk("stall_product", 32'(p), 32'h0438);
               chk("stall_in_ready", 32'(ir), 32'd0);
            end
            ordy = 1'b1;
            @(posedge clk);
            #1 chk("stall_release_idle", 32'(ir), 32'd1);
            @(posedge clk);
            #1 iv = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("stall_next_valid", 32'(ov), 32'd1);
            chk("stall_next_product", 32'(p), 32'h471F);
            @(posedge clk);
            #1;

            // Reset during the second CALC cycle discards the operation.
            iv = 1'b1;
            a  = 8'hAB;
            b  = 8'hCD;
            @(posedge clk);
            #1 iv = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1 rst_vals("midrst");
            @(negedge clk) rst_n = 1'b1;
            repeat (6) begin
               @(negedge clk);
               chk("midrst_no_valid", 32'(ov), 32'd0);
            end
            @(posedge clk);
            #1 xact(8'h12, 8'h34, 16'h03A8, 32'h24_23_14_13);

            start_rnd = 1'b1;
            finished++;
         end
      end else begin : g_rnd
         initial begin
            bit          take;
            int unsigned n, cyc;
            iv   = 1'b0;
            a    = '0;
            b    = '0;
            ordy = 1'b1;
            wait (start_rnd);
            @(posedge clk);
            #1;
            n   = 0;
            cyc = 0;
            iv  = 1'b1;
            a   = '1;
            b   = '1;
            while (n < 1000 && cyc < 60000) begin
               @(negedge clk);
               take = iv && ir;
               @(posedge clk);
               #1;
               cyc++;
               ordy = ($urandom_range(0, 3) != 0);
               if (take) begin
                  n++;
                  a = (n == 1) ? '0 : WG'($urandom);
                  b = WG'($urandom);
               end
            end
            iv   = 1'b0;
            ordy = 1'b1;
            chk($sformatf("w%0d_accepted", WG), n, 32'd1000);
            cyc = 0;
            while (bsy && cyc < 100) begin
               @(posedge clk);
               #1 cyc++;
            end
            chk($sformatf("w%0d_drained", WG), 32'(bsy), 32'd0);
            finished++;
         end
      end
   end

   initial begin
      int unsigned cyc;
      cyc = 0;
      while (finished < 3 && cyc < 90000) begin
         @(posedge clk);
         cyc++;
      end
      chk("all_done", finished, 32'd3);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
